// File: rtl/instr_loader.sv
// Encodes RV32I requests (ADD/ADDI/BEQ/BNE/JALR/JAL) and streams each accepted
// word into a byte-wide instruction memory, least significant byte first.
module instr_loader #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         kind,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [D_WIDTH-1:0] imm,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  output logic [D_WIDTH-1:0] instr,
  output logic               err,
  output logic [15:0]        count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB0  = 3'd1,
    S_WB1  = 3'd2,
    S_WB2  = 3'd3,
    S_WB3  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [A_WIDTH-1:0]        r_waddr;
  logic [D_WIDTH-1:0]        r_instr;
  logic                      r_err;
  logic [15:0]               r_count;
  logic                      w_accept;
  logic                      w_legal;
  logic [31:0]               w_word;
  logic signed [D_WIDTH-1:0] w_imm;

  assign w_imm    = $signed(imm);
  assign w_accept = in_valid && in_ready;

  // Encoder and legality check; the immediate range depends on the format.
  always_comb begin
    w_word  = 32'd0;
    w_legal = 1'b0;
    case (kind)
      3'd0: begin
        w_word  = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
        w_legal = 1'b1;
      end
      3'd1: begin
        w_word  = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        w_legal = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
      end
      3'd2, 3'd3: begin
        w_word  = {imm[12], imm[10:5], rs2, rs1, {2'b00, kind[0]},
                   imm[4:1], imm[11], 7'b1100011};
        w_legal = (w_imm >= -32'sd4096) && (w_imm <= 32'sd4094) && !imm[0];
      end
      3'd4: begin
        w_word  = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        w_legal = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
      end
      3'd5: begin
        w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        w_legal = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048574) && !imm[0];
      end
      default: begin
        w_word  = 32'd0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Next-state: a legal acceptance starts the four byte-write cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          w_next = S_WB0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WB0:   w_next = S_WB1;
      S_WB1:   w_next = S_WB2;
      S_WB2:   w_next = S_WB3;
      S_WB3:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory port decode; idle drives the current write address with no data.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    mem_we    = 1'b0;
    mem_addr  = r_waddr;
    mem_wdata = 8'd0;
    case (r_state)
      S_WB0: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr;
        mem_wdata = r_instr[7:0];
      end
      S_WB1: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr + A_WIDTH'(3'd1);
        mem_wdata = r_instr[15:8];
      end
      S_WB2: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr + A_WIDTH'(3'd2);
        mem_wdata = r_instr[23:16];
      end
      S_WB3: begin
        mem_we    = 1'b1;
        mem_addr  = r_waddr + A_WIDTH'(3'd3);
        mem_wdata = r_instr[31:24];
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = r_waddr;
        mem_wdata = 8'd0;
      end
    endcase
  end

  // State, latched word, error pulse, write pointer and completed-word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_instr <= D_WIDTH'(w_word);
      end
      if (r_state == S_WB3) begin
        r_waddr <= r_waddr + A_WIDTH'(3'd4);
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign instr = r_instr;
  assign err   = r_err;
  assign count = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed vector table, reset/throughput
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [31:0] instr;
  logic        err;
  logic [15:0] count;

  instr_loader #(.D_WIDTH(32), .A_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr(instr), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: remaining write cycles of the current word, plus architectural state
  int          m_busy = 0;
  logic [7:0]  m_waddr = 8'd0;
  logic [15:0] m_count = 16'd0;
  logic [31:0] m_instr = 32'd0;
  logic        m_err = 1'b0;
  logic [7:0]  tb_mem [256];

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          ok;
    logic [31:0] word;   // expected instr after the request
    logic [7:0]  base;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[20];
  int   bnd[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference encoder built from field arithmetic; returns {legal, word}
  function automatic logic [32:0] ref_encode(input logic [2:0] k, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] im);
    longint v  = longint'($signed(im));
    longint ld = longint'(d);
    longint l1 = longint'(s1);
    longint l2 = longint'(s2);
    longint w  = 0;
    bit     ok = 0;
    case (k)
      3'd0: begin ok = 1; w = (l2 << 20) | (l1 << 15) | (ld << 7) | 'h33; end
      3'd1, 3'd4: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = ((v & 'hFFF) << 20) | (l1 << 15) | (ld << 7) | ((k == 3'd1) ? 'h13 : 'h67);
      end
      3'd2, 3'd3: begin
        ok = (v >= -4096) && (v <= 4094) && ((v & 1) == 0);
        w  = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (l2 << 20) | (l1 << 15) |
             ((k == 3'd3 ? 1 : 0) << 12) | (((v >> 1) & 'hF) << 8) | (((v >> 11) & 1) << 7) | 'h63;
      end
      3'd5: begin
        ok = (v >= -1048576) && (v <= 1048574) && ((v & 1) == 0);
        w  = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20) |
             (((v >> 12) & 'hFF) << 12) | (ld << 7) | 'h6F;
      end
      default: begin ok = 0; w = 0; end
    endcase
    return {ok, w[31:0]};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    logic        s_rst = rst;
    logic        s_val = in_valid;
    logic [32:0] e;
    int          n;
    e = ref_encode(kind, rd, rs1, rs2, imm);
    @(posedge clk);
    if (s_rst) begin
      m_busy = 0; m_waddr = 8'd0; m_count = 16'd0; m_instr = 32'd0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_waddr = m_waddr + 8'd4;
          m_count = m_count + 16'd1;
        end
      end else if (s_val) begin
        if (e[32]) begin
          m_instr = e[31:0];
          m_busy  = 4;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #1;
    n = (m_busy > 0) ? 4 - m_busy : 0;
    chk("in_ready", in_ready, (m_busy == 0) && !rst);
    chk("mem_we", mem_we, m_busy > 0);
    chk("mem_addr", mem_addr, m_waddr + 8'(n));
    chk("mem_wdata", mem_wdata, (m_busy > 0) ? m_instr[8*n +: 8] : 8'd0);
    chk("instr", instr, m_instr);
    chk("err", err, m_err);
    chk("count", count, m_count);
    if (mem_we === 1'b1) tb_mem[mem_addr] = mem_wdata;
  endtask

  task automatic set_req(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im);
    kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic scramble();
    set_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
  endtask

  function automatic logic [31:0] rand_imm();
    int t;
    case ($urandom_range(0, 3))
      0: t = bnd[$urandom_range(0, 13)];
      1: t = int'($urandom_range(0, 8191)) - 4096;
      2: t = int'($urandom);
      default: t = int'($urandom_range(0, 4194304)) - 2097152;
    endcase
    return 32'(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    bnd = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096,
            1048576, -1048576, 1048574, 1048575, -1048578};
    tbl[0]  = '{3'd1, 5'd1,  5'd0,  5'd0,  32'd5,          1, 32'h0050_0093, 8'd0,  16'd1};
    tbl[1]  = '{3'd0, 5'd3,  5'd1,  5'd2,  32'd0,          1, 32'h0020_81B3, 8'd4,  16'd2};
    tbl[2]  = '{3'd3, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFF8,  1, 32'hFE20_9CE3, 8'd8,  16'd3};
    tbl[3]  = '{3'd5, 5'd1,  5'd0,  5'd0,  32'd16,         1, 32'h0100_00EF, 8'd12, 16'd4};
    tbl[4]  = '{3'd7, 5'd1,  5'd1,  5'd1,  32'd0,          0, 32'h0100_00EF, 8'd0,  16'd4};
    tbl[5]  = '{3'd1, 5'd1,  5'd0,  5'd0,  32'd2048,       0, 32'h0100_00EF, 8'd0,  16'd4};
    tbl[6]  = '{3'd2, 5'd0,  5'd1,  5'd2,  32'd3,          0, 32'h0100_00EF, 8'd0,  16'd4};
    tbl[7]  = '{3'd1, 5'd2,  5'd0,  5'd0,  32'hFFFF_F800,  1, 32'h8000_0113, 8'd16, 16'd5};
    tbl[8]  = '{3'd4, 5'd1,  5'd5,  5'd0,  32'd2047,       1, 32'h7FF2_80E7, 8'd20, 16'd6};
    tbl[9]  = '{3'd2, 5'd0,  5'd0,  5'd0,  32'd4094,       1, 32'h7E00_0FE3, 8'd24, 16'd7};
    tbl[10] = '{3'd2, 5'd0,  5'd0,  5'd0,  32'hFFFF_F000,  1, 32'h8000_0063, 8'd28, 16'd8};
    tbl[11] = '{3'd3, 5'd0,  5'd0,  5'd0,  32'd4096,       0, 32'h8000_0063, 8'd0,  16'd8};
    tbl[12] = '{3'd5, 5'd0,  5'd0,  5'd0,  32'h0010_0000,  0, 32'h8000_0063, 8'd0,  16'd8};
    tbl[13] = '{3'd5, 5'd0,  5'd0,  5'd0,  32'hFFF0_0000,  1, 32'h8000_006F, 8'd32, 16'd9};
    tbl[14] = '{3'd5, 5'd1,  5'd0,  5'd0,  32'd3,          0, 32'h8000_006F, 8'd0,  16'd9};
    tbl[15] = '{3'd6, 5'd1,  5'd1,  5'd1,  32'd0,          0, 32'h8000_006F, 8'd0,  16'd9};
    tbl[16] = '{3'd0, 5'd31, 5'd31, 5'd31, 32'h7FFF_FFFF,  1, 32'h01FF_8FB3, 8'd36, 16'd10};
    tbl[17] = '{3'd1, 5'd1,  5'd0,  5'd0,  32'hFFFF_F7FF,  0, 32'h01FF_8FB3, 8'd0,  16'd10};
    tbl[18] = '{3'd5, 5'd0,  5'd0,  5'd0,  32'h000F_FFFE,  1, 32'h7FFF_F06F, 8'd40, 16'd11};
    tbl[19] = '{3'd4, 5'd1,  5'd0,  5'd0,  32'd2048,       0, 32'h7FFF_F06F, 8'd0,  16'd11};
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'd0;

    rst = 1'b1; in_valid = 1'b0; set_req(3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    chk("reset_ready", in_ready, 1'b0);
    chk("reset_count", count, 16'd0);
    chk("reset_instr", instr, 32'd0);
    rst = 1'b0; #1;
    chk("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 20; i++) begin
      chk("tbl_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      set_req(tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      tick();
      in_valid = 1'b0; scramble();
      chk("tbl_err", err, !tbl[i].ok);
      chk("tbl_instr", instr, tbl[i].word);
      if (tbl[i].ok) begin
        repeat (4) tick();
        for (int j = 0; j < 4; j++)
          chk("tbl_byte", tb_mem[tbl[i].base + 8'(j)], tbl[i].word[8*j +: 8]);
      end else begin
        tick();
        chk("tbl_err_clear", err, 1'b0);
      end
      chk("tbl_count", count, tbl[i].cnt);
    end

    // reset in the middle of a word
    in_valid = 1'b1; set_req(3'd1, 5'd1, 5'd0, 5'd0, 32'd5);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("wb2_we", mem_we, 1'b1);
    rst = 1'b1; tick();
    chk("abort_we", mem_we, 1'b0);
    chk("abort_count", count, 16'd0);
    tick();
    chk("rst_held_ready", in_ready, 1'b0);
    rst = 1'b0; #1;
    chk("rst_release_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) tb_mem[i] = 8'd0;
    in_valid = 1'b1; set_req(3'd1, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick(); in_valid = 1'b0; repeat (4) tick();
    chk("post_rst_b0", tb_mem[0], 8'h13);
    chk("post_rst_b1", tb_mem[1], 8'h01);
    chk("post_rst_b2", tb_mem[2], 8'hF0);
    chk("post_rst_b3", tb_mem[3], 8'hFF);
    chk("post_rst_count", count, 16'd1);

    // continuous in_valid
    accepts = 0;
    in_valid = 1'b1; set_req(3'd1, 5'd1, 5'd0, 5'd0, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) accepts++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_accepts", accepts, 4);
    chk("stream_count", count, 16'd5);

    // random traffic, long reset-free stretch so the address wraps
    for (int i = 0; i < 1600; i++) begin
      rst = (i >= 1200) && ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      set_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
